pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, exception flush/redirect,
// debug halt with bounded drain, stall statistics and a consecutive-stall watchdog.
module pipe_ctrl #(
    parameter int unsigned STALL_LIMIT  = 1024,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_req_i,
    input  logic [31:0] exc_vector_i,
    input  logic        halt_req_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        halted_o,
    output logic [31:0] stall_cnt_o,
    output logic        stall_timeout_o
);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

    state_t      state;
    logic [5:0]  req_vec;
    logic [31:0] drain_cnt;
    logic [31:0] consec_cnt;

    // Deepest stalling stage wins; everything upstream of it holds too.
    always_comb begin
        req_vec = 6'b000000;
        if (stallreq_mem)     req_vec = 6'b011111;
        else if (stallreq_ex) req_vec = 6'b001111;
        else if (stallreq_id) req_vec = 6'b000111;
        else if (stallreq_if) req_vec = 6'b000011;
    end

    always_comb begin
        stall_o = req_vec;
        case (state)
            RUN:     stall_o = req_vec;
            FLUSH:   stall_o = 6'b000000;
            DRAIN:   stall_o = {req_vec[5:2], 2'b11};
            HALTED:  stall_o = 6'b111111;
            default: stall_o = req_vec;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            flush_o         <= 1'b0;
            new_pc_o        <= 32'd0;
            halted_o        <= 1'b0;
            stall_cnt_o     <= 32'd0;
            stall_timeout_o <= 1'b0;
            drain_cnt       <= 32'd0;
            consec_cnt      <= 32'd0;
        end else begin
            if (stall_o[0] && (state == RUN || state == DRAIN))
                stall_cnt_o <= stall_cnt_o + 32'd1;

            case (state)
                RUN: begin
                    if (stall_o != 6'd0) begin
                        if (consec_cnt < 32'(STALL_LIMIT))
                            consec_cnt <= consec_cnt + 32'd1;
                        if (consec_cnt + 32'd1 >= 32'(STALL_LIMIT))
                            stall_timeout_o <= 1'b1;
                    end else begin
                        consec_cnt <= 32'd0;
                    end
                    if (exc_req_i) begin
                        flush_o  <= 1'b1;
                        new_pc_o <= exc_vector_i;
                        state    <= FLUSH;
                    end else if (halt_req_i) begin
                        drain_cnt <= 32'd0;
                        state     <= DRAIN;
                    end
                end
                FLUSH: begin
                    flush_o    <= 1'b0;
                    consec_cnt <= 32'd0;
                    drain_cnt  <= 32'd0;
                    state      <= halt_req_i ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (exc_req_i) begin
                        flush_o   <= 1'b1;
                        new_pc_o  <= exc_vector_i;
                        drain_cnt <= 32'd0;
                        state     <= FLUSH;
                    end else if (!halt_req_i) begin
                        drain_cnt <= 32'd0;
                        state     <= RUN;
                    end else if (!stallreq_ex && !stallreq_mem) begin
                        // Only cycles where EX/MEM make progress count toward the drain.
                        if (drain_cnt + 32'd1 >= 32'(DRAIN_CYCLES)) begin
                            drain_cnt <= 32'd0;
                            halted_o  <= 1'b1;
                            state     <= HALTED;
                        end else begin
                            drain_cnt <= drain_cnt + 32'd1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req_i) begin
                        halted_o <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-level behavioural model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_pipe_ctrl;
    localparam int SL = 8;
    localparam int DC = 4;
    localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_req_i, halt_req_i;
    logic [31:0] exc_vector_i;
    logic [5:0]  stall_o;
    logic        flush_o, halted_o, stall_timeout_o;
    logic [31:0] new_pc_o, stall_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_LIMIT(SL), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_req_i(exc_req_i), .exc_vector_i(exc_vector_i), .halt_req_i(halt_req_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .halted_o(halted_o),
        .stall_cnt_o(stall_cnt_o), .stall_timeout_o(stall_timeout_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode = M_RUN;
    logic        m_flush = 1'b0, m_halted = 1'b0, m_to = 1'b0;
    logic [31:0] m_pc = 32'd0, m_cnt = 32'd0;
    int          m_run_len = 0, m_drained = 0;

    // Stall mask = all stages up to and including the deepest requesting one.
    function automatic logic [5:0] deepest_mask();
        int d;
        d = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
        return 6'((1 << d) - 1);
    endfunction

    function automatic logic [5:0] model_stall();
        case (m_mode)
            M_FLUSH: return 6'd0;
            M_DRAIN: return deepest_mask() | 6'd3;
            M_HALT:  return 6'd63;
            default: return deepest_mask();
        endcase
    endfunction

    task model_reset();
        m_mode = M_RUN; m_flush = 0; m_halted = 0; m_to = 0;
        m_pc = 0; m_cnt = 0; m_run_len = 0; m_drained = 0;
    endtask

    task model_step(input logic [5:0] st);
        if ((m_mode == M_RUN || m_mode == M_DRAIN) && st[0]) m_cnt = m_cnt + 1;
        case (m_mode)
            M_RUN: begin
                if (st != 0) begin
                    if (m_run_len < SL) m_run_len++;
                    if (m_run_len >= SL) m_to = 1;
                end else m_run_len = 0;
                if (exc_req_i) begin m_flush = 1; m_pc = exc_vector_i; m_mode = M_FLUSH; end
                else if (halt_req_i) begin m_drained = 0; m_mode = M_DRAIN; end
            end
            M_FLUSH: begin
                m_flush = 0; m_run_len = 0; m_drained = 0;
                m_mode = halt_req_i ? M_DRAIN : M_RUN;
            end
            M_DRAIN: begin
                if (exc_req_i) begin m_flush = 1; m_pc = exc_vector_i; m_drained = 0; m_mode = M_FLUSH; end
                else if (!halt_req_i) begin m_drained = 0; m_mode = M_RUN; end
                else if (!stallreq_ex && !stallreq_mem) begin
                    m_drained++;
                    if (m_drained == DC) begin m_drained = 0; m_halted = 1; m_mode = M_HALT; end
                end
            end
            default: if (!halt_req_i) begin m_halted = 0; m_mode = M_RUN; end
        endcase
    endtask

    initial begin
        forever begin
            logic [5:0] es;
            @(negedge clk);
            if (rst) model_reset();
            es = model_stall();
            chk("model stall_o", stall_o, es);
            chk("model flush_o", flush_o, m_flush);
            chk("model halted_o", halted_o, m_halted);
            chk("model stall_cnt_o", stall_cnt_o, m_cnt);
            chk("model stall_timeout_o", stall_timeout_o, m_to);
            if (m_flush) chk("model new_pc_o", new_pc_o, m_pc);
            if (!rst) model_step(es);
        end
    end

    // ---------------- stimulus ----------------
    task tick(); @(posedge clk); #1; endtask

    task idle();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_req_i = 0; halt_req_i = 0; exc_vector_i = 0;
    endtask

    initial begin
        idle(); rst = 1;
        @(negedge clk);
        chk("reset stall_o", stall_o, 0);
        chk("reset flush_o", flush_o, 0);
        chk("reset new_pc_o", new_pc_o, 0);
        chk("reset halted_o", halted_o, 0);
        chk("reset stall_cnt_o", stall_cnt_o, 0);
        chk("reset timeout", stall_timeout_o, 0);
        tick(); rst = 0;

        // id + mem together: mem priority wins
        tick(); stallreq_id = 1; stallreq_mem = 1;
        @(negedge clk); chk("id+mem stall_o", stall_o, 6'b011111);
        tick(); idle();
        @(negedge clk); chk("stall_cnt after one stall", stall_cnt_o, 1);

        // exception overrides an EX stall
        tick(); exc_req_i = 1; exc_vector_i = 32'h20; stallreq_ex = 1;
        @(negedge clk); chk("ex stall_o", stall_o, 6'b001111);
        tick(); idle();
        @(negedge clk);
        chk("exc flush_o", flush_o, 1);
        chk("exc new_pc_o", new_pc_o, 32'h20);
        chk("flush stall_o", stall_o, 0);
        tick();
        @(negedge clk); chk("flush drops", flush_o, 0);

        // halt with mem stalling the first 3 drain cycles
        tick(); halt_req_i = 1;
        tick(); stallreq_mem = 1;
        tick(); tick();
        tick(); stallreq_mem = 0;
        tick(); tick(); tick();
        @(negedge clk); chk("drain cycle 7 not halted", halted_o, 0);
        tick();
        @(negedge clk);
        chk("halted after 3+DC", halted_o, 1);
        chk("halted stall_o", stall_o, 6'b111111);
        chk("stall_cnt after drain", stall_cnt_o, 9);
        tick(); exc_req_i = 1; exc_vector_i = 32'h40;
        tick(); exc_req_i = 0;
        @(negedge clk);
        chk("exc ignored in halted", flush_o, 0);
        chk("still halted", halted_o, 1);
        tick(); halt_req_i = 0;
        tick();
        @(negedge clk); chk("resume from halt", halted_o, 0);

        // exception and halt together: flush first, then drain
        tick(); exc_req_i = 1; halt_req_i = 1; exc_vector_i = 32'h100;
        tick(); exc_req_i = 0;
        @(negedge clk);
        chk("exc+halt flush_o", flush_o, 1);
        chk("exc+halt new_pc_o", new_pc_o, 32'h100);
        tick(); tick(); tick(); tick();
        @(negedge clk); chk("exc+halt drain 4 not halted", halted_o, 0);
        tick();
        @(negedge clk); chk("exc+halt halted", halted_o, 1);
        tick(); halt_req_i = 0;
        tick();

        // halt dropped during drain returns to run
        tick(); halt_req_i = 1; stallreq_id = 1;
        tick();
        @(negedge clk); chk("drain id stall_o", stall_o, 6'b000111);
        halt_req_i = 0;
        tick();
        @(negedge clk); chk("back in run stall_o", stall_o, 6'b000111);

        // exception during drain clears the drain progress
        tick(); idle(); halt_req_i = 1;
        tick(); exc_req_i = 1; exc_vector_i = 32'h80;
        tick(); exc_req_i = 0;
        @(negedge clk); chk("drain exc new_pc_o", new_pc_o, 32'h80);
        tick(); tick(); tick(); tick();
        @(negedge clk); chk("redrain 4 not halted", halted_o, 0);
        tick();
        @(negedge clk); chk("redrain halted", halted_o, 1);
        tick(); halt_req_i = 0;
        tick(); tick();

        // watchdog: STALL_LIMIT consecutive IF stalls
        tick(); stallreq_if = 1;
        repeat (7) tick();
        @(negedge clk); chk("timeout cycle 8", stall_timeout_o, 0);
        tick();
        @(negedge clk); chk("timeout cycle 9", stall_timeout_o, 1);
        tick(); stallreq_if = 0;
        repeat (3) tick();
        @(negedge clk); chk("timeout sticky", stall_timeout_o, 1);

        // reset mid-flush: pulse abandoned
        tick(); exc_req_i = 1; exc_vector_i = 32'h44;
        tick(); exc_req_i = 0;
        #1 rst = 1;
        #1;
        chk("rst mid-flush flush_o", flush_o, 0);
        chk("rst clears timeout", stall_timeout_o, 0);
        chk("rst clears stall_cnt", stall_cnt_o, 0);
        tick(); rst = 0;
        tick();
        @(negedge clk); chk("no flush after rst", flush_o, 0);

        // reset mid-drain
        tick(); halt_req_i = 1;
        tick(); tick();
        #1 rst = 1; halt_req_i = 0;
        #1;
        chk("rst mid-drain stall_o", stall_o, 0);
        chk("rst mid-drain halted_o", halted_o, 0);
        chk("rst mid-drain new_pc_o", new_pc_o, 0);
        tick(); rst = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk); chk("never halts after rst", halted_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
